// File: rtl/edsac_memctl.sv
// edsac_memctl: arbitrates the initial-orders loader (write-only) and the CPU onto one 2**ABITS x 16 store.
// Define EDSAC_DELAY_LINE_EN to emulate the mercury delay-line rotation, so a word is reachable only as it passes the head.
module edsac_memctl #(
    parameter int ABITS = 9,
    parameter int SLOTS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ABITS-1:0] init_addr,
    input  logic [15:0]      init_wdata,
    input  logic             init_wr,
    output logic             init_wait,
    input  logic [ABITS-1:0] cpu_addr,
    input  logic [15:0]      cpu_wdata,
    input  logic             cpu_wr,
    input  logic             cpu_rd,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_wait,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, INIT_ACC, CPU_ACC} state_t;

    state_t      state;
    logic [15:0] mem [0:(1<<ABITS)-1];
    logic        complete;
    logic        init_we;
    logic        cpu_we;

    if (SLOTS < 2 || SLOTS > (1 << ABITS) || (SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
        $error("SLOTS must be a power of two between 2 and 2**ABITS");
    end

`ifdef EDSAC_DELAY_LINE_EN
    localparam int PW = $clog2(SLOTS);

    logic [PW-1:0] pos;

    always_ff @(posedge clk) begin
        if (rst)
            pos <= '0;
        else
            pos <= pos + 1'b1;
    end

    // The slot under the head must match the low address bits of whoever is being served.
    always_comb begin
        if (state == INIT_ACC)
            complete = (pos == init_addr[PW-1:0]);
        else
            complete = (pos == cpu_addr[PW-1:0]);
    end
`else
    assign complete = 1'b1;
`endif

    assign init_wait = init_wr & ~((state == INIT_ACC) & complete);
    assign cpu_wait  = (cpu_wr | cpu_rd) & ~((state == CPU_ACC) & complete);

    // Reset in the completing cycle must suppress the store update.
    assign init_we = ~rst & init_wr & (state == INIT_ACC) & complete;
    assign cpu_we  = ~rst & cpu_wr & (state == CPU_ACC) & complete;

    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_addr] <= init_wdata;
        else if (cpu_we)
            mem[cpu_addr] <= cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cpu_rdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (init_wr) begin
                        state <= INIT_ACC;
                        busy  <= 1'b1;
                    end else if (cpu_wr | cpu_rd) begin
                        state <= CPU_ACC;
                        busy  <= 1'b1;
                    end
                end
                INIT_ACC: begin
                    if (!init_wr || complete) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CPU_ACC: begin
                    if (!(cpu_wr | cpu_rd)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (complete) begin
                        if (!cpu_wr)
                            cpu_rdata <= mem[cpu_addr];
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/edsac_memctl.md
Name: edsac_memctl

Overview:
- Single-bank main-store controller sitting directly downstream of the initial-orders loader.
- Arbitrates two requesters onto one 2**ABITS x 16 storage array: the loader's write-only port (init_*) and the CPU's read/write port (cpu_*).
- Generates the wait handshake both requesters stall on.
- Can optionally emulate EDSAC mercury delay-line access timing.

Parameters:
ABITS, 9, address width; array depth 2**ABITS words of 16 bits
SLOTS, 32, words per delay line; power of two, <= 2**ABITS; used only with DELAY_LINE_EN

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
init_addr  in  ABITS  loader write address
init_wdata  in  16  loader write data
init_wr  in  1  loader write request, level, held until accepted
init_wait  out  1  stall to loader; loader advances on rising clk when init_wait=0
cpu_addr  in  ABITS  CPU address
cpu_wdata  in  16  CPU write data
cpu_wr  in  1  CPU write request, level
cpu_rd  in  1  CPU read request, level
cpu_rdata  out  16  registered read data
cpu_wait  out  1  stall to CPU
busy  out  1  registered, 1 whenever state != IDLE

Behaviour:
- State machine states: IDLE, INIT_ACC, CPU_ACC.
- Reset values: state=IDLE, cpu_rdata=0, busy=0, slot counter=0. Array contents are not cleared.
- init_wait = init_wr & ~(state==INIT_ACC & complete). Combinational from state.
- cpu_wait = (cpu_wr|cpu_rd) & ~(state==CPU_ACC & complete). Combinational from state.
- IDLE:
  - init_wr=1 -> INIT_ACC; init has fixed priority, even if CPU is requesting.
  - else cpu_wr or cpu_rd -> CPU_ACC.
  - else stay.
  - Addresses and data are NOT latched; requesters hold them stable until wait=0.
- INIT_ACC:
  - If init_wr drops -> IDLE, no write (abort).
  - Else, when complete=1: mem[init_addr] <= init_wdata at the clock edge; -> IDLE.
- CPU_ACC:
  - If cpu_wr and cpu_rd both drop -> IDLE, no access.
  - Else, when complete=1:
    - cpu_wr=1: mem[cpu_addr] <= cpu_wdata. Write wins if cpu_rd is also high; cpu_rdata unchanged.
    - cpu_wr=0: cpu_rdata <= mem[cpu_addr].
  - Then -> IDLE.
  - cpu_rdata holds its value until the next completed read.
- complete without DELAY_LINE_EN: constant 1. Every access takes exactly 2 cycles (IDLE then ACC); a continuously requesting loader writes one word per 2 cycles.
- Back-to-back: after a completed CPU access, a pending init_wr wins the next IDLE cycle. No fairness guarantee for the CPU while the loader streams.
- Reset mid-access: state -> IDLE, pending write suppressed, cpu_rdata -> 0.
- Wait outputs are 0 whenever the corresponding request is 0.

Optional Feature:
- Macro: EDSAC_DELAY_LINE_EN.
- Defined:
  - A free-running slot counter pos, log2(SLOTS) bits, counts 0..SLOTS-1 and wraps every cycle from reset.
  - complete = (pos == addr[log2(SLOTS)-1:0]) for the requester being served.
  - Access latency is 2..SLOTS+1 cycles depending on rotation; the word is accessed only as it "passes the head".
  - Abort and priority rules are unchanged.
- Undefined: no counter is synthesised; fixed 2-cycle access as above.

Test Plan:
- Reset, then init_wr=1 with addr 0..37 driven per loader protocol, no DELAY_LINE_EN -> 38 writes in 76 cycles; init_wait alternates 1,0; CPU reads of addr 0 then 37 return 0xA01E and 0x0000.
- init_wr and cpu_rd asserted the same cycle in IDLE -> INIT_ACC first; cpu_wait stays 1 until init completes; the CPU read then finishes 2 cycles later.
- CPU write 0x1234 to addr 5, then read addr 5 -> cpu_rdata=0x1234 after 4 cycles total; cpu_rdata=0 before.
- cpu_wr deasserted during CPU_ACC under DELAY_LINE_EN before slot match -> no write; mem[addr] retains old value; state back to IDLE next cycle.
- DELAY_LINE_EN, SLOTS=32: read addr 40 issued when pos=3 -> completes in the cycle pos=8 (latency 6); read addr 3 issued at pos=3 -> pos=4 at ACC, wraps, completes at pos=3 (latency 33).
- rst asserted in CPU_ACC with cpu_wr=1 -> no write; busy=0, cpu_rdata=0 the next cycle.
